// File: rtl/multdiv_unit.sv
// multdiv_unit -- multi-cycle signed multiply / divide for the execute stage.
//
// A start (ctrl_MULT or ctrl_DIV) accepted in IDLE/DONE latches both operands.
// Multiply takes WIDTH radix-2 Booth steps; divide takes WIDTH restoring steps on
// operand magnitudes and fixes the quotient sign at the end. The result and
// exception are registered on the final step and presented with a one-cycle
// data_resultRDY pulse. flush aborts an in-flight op without touching outputs.
//
// Ports
//   clock, reset      : rising-edge clock, asynchronous active-low reset
//   ctrl_MULT/ctrl_DIV: start strobes (MULT wins if both are high)
//   flush             : squash the in-flight op / ignore a start this edge
//   data_operandA/B   : two's complement operands (multiplicand/dividend, multiplier/divisor)
//   data_result       : low WIDTH bits of product, or quotient
//   data_exception    : overflow or divide-by-zero, valid with data_resultRDY
//   data_resultRDY    : one-cycle result-valid pulse
//   busy              : high while iterating (pipeline stall)
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // Shared accumulator: multiply uses {upper(W+1), multiplier(W)},
    // divide uses {remainder(W+1), dividend/quotient(W)}.
    logic [2*WIDTH:0]     prod_q, prod_d;
    logic                 booth_q, booth_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 exc_q, exc_d;

    logic [WIDTH:0]       u_sum, m_ext, rem_sh, trial;
    logic [2*WIDTH:0]     mul_next, div_next;
    logic [WIDTH:0]       mul_top;
    logic [WIDTH-1:0]     div_quot, abs_a, abs_b;
    logic                 last;

    assign last  = (cnt_q == CNT_W'(WIDTH-1));
    assign abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

    // Booth step. The upper half is one bit wider than WIDTH so adding or
    // subtracting a MIN_INT multiplicand cannot overflow the partial sum.
    always_comb begin
        m_ext = {mcand_q[WIDTH-1], mcand_q};
        unique case ({prod_q[0], booth_q})
            2'b01:   u_sum = prod_q[2*WIDTH:WIDTH] + m_ext;
            2'b10:   u_sum = prod_q[2*WIDTH:WIDTH] - m_ext;
            default: u_sum = prod_q[2*WIDTH:WIDTH];
        endcase
        mul_next = {u_sum[WIDTH], u_sum, prod_q[WIDTH-1:1]};
        mul_top  = mul_next[2*WIDTH-1:WIDTH-1];
    end

    // Restoring division step on magnitudes; quotient bits shift in at the bottom.
    always_comb begin
        rem_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        trial    = rem_sh - {1'b0, mcand_q};
        div_next = trial[WIDTH] ? {rem_sh, prod_q[WIDTH-2:0], 1'b0}
                                : {trial,  prod_q[WIDTH-2:0], 1'b1};
        div_quot = div_next[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        booth_d  = booth_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        result_d = result_q;
        exc_d    = exc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (!flush && (ctrl_MULT || ctrl_DIV)) begin
                    cnt_d = '0;
                    if (ctrl_MULT) begin
                        state_d = S_MUL;
                        prod_d  = {{(WIDTH+1){1'b0}}, data_operandB};
                        booth_d = 1'b0;
                        mcand_d = data_operandA;
                    end else begin
                        state_d = S_DIV;
                        prod_d  = {{(WIDTH+1){1'b0}}, abs_a};
                        mcand_d = abs_b;
                        neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d  = mul_next;
                    booth_d = prod_q[0];
                    if (last) begin
                        state_d  = S_DONE;
                        result_d = mul_next[WIDTH-1:0];
                        exc_d    = ~((&mul_top) | ~(|mul_top));
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mcand_q == '0) begin
                    state_d  = S_DONE;
                    result_d = '0;
                    exc_d    = 1'b1;
                end else begin
                    prod_d = div_next;
                    if (last) begin
                        state_d  = S_DONE;
                        result_d = neg_q ? (~div_quot + 1'b1) : div_quot;
                        // Only MIN_INT / -1 yields a positive quotient with the top bit set.
                        exc_d    = ~neg_q & div_quot[WIDTH-1];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            booth_q  <= 1'b0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            booth_q  <= booth_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == S_DONE);
    assign busy           = (state_q == S_MUL) || (state_q == S_DIV);

endmodule

// File: tb/tb_multdiv_unit.sv
module tb_multdiv_unit;
    localparam int W = 32;

    logic          clock;
    logic          reset;
    logic          ctrl_MULT, ctrl_DIV, flush;
    logic [W-1:0]  data_operandA, data_operandB;
    logic [W-1:0]  data_result;
    logic          data_exception, data_resultRDY, busy;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .flush          (flush),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_active, m_rdy, m_exc, p_exc;
    logic [W-1:0] m_res, p_res;
    int           m_left;

    task automatic model_op(input bit mul, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] res, output bit exc);
        longint p;
        int     sa, sb;
        if (mul) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            res = p[W-1:0];
            exc = (p != longint'($signed(res)));
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            if (sb == 0) begin
                res = '0; exc = 1'b1;
            end else if (a == 32'h8000_0000 && sb == -1) begin
                res = 32'h8000_0000; exc = 1'b1;
            end else begin
                res = sa / sb; exc = 1'b0;
            end
        end
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_active = 0; m_rdy = 0; m_res = '0; m_exc = 0; m_left = 0;
        end else begin
            m_rdy = 0;
            if (m_active) begin
                if (flush) m_active = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_active = 0; m_rdy = 1; m_res = p_res; m_exc = p_exc;
                    end
                end
            end else if (!flush && (ctrl_MULT || ctrl_DIV)) begin
                model_op(ctrl_MULT, data_operandA, data_operandB, p_res, p_exc);
                m_left   = (!ctrl_MULT && data_operandB == '0) ? 1 : W;
                m_active = 1;
            end
        end
    end

    // Single compare process: every cycle, all outputs against the model.
    always @(negedge clock) begin
        check("busy",   busy,           m_active);
        check("rdy",    data_resultRDY, m_rdy);
        check("result", data_result,    m_res);
        check("exc",    data_exception, m_exc);
    end

    // ---------------- directed helpers ----------------
    task automatic wait_rdy(output int lat, output bit seen);
        lat = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin seen = 1; break; end
            @(posedge clock);
            lat++;
        end
    endtask

    task automatic op_lit(input string name, input bit mul, input bit div,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input bit ee, input int el);
        int lat; bit seen;
        @(posedge clock); #1;
        ctrl_MULT = mul; ctrl_DIV = div; data_operandA = a; data_operandB = b;
        @(posedge clock); #1;
        ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = $urandom; data_operandB = $urandom;
        wait_rdy(lat, seen);
        check({name, "_seen"}, seen, 1);
        if (seen) begin
            check({name, "_result"}, data_result, er);
            check({name, "_exc"}, data_exception, ee);
            check({name, "_lat"}, lat, el);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_0001;
            5, 6: return 32'($signed(16'($urandom)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat; bit seen; int rdy_cnt;
        reset = 0; ctrl_MULT = 0; ctrl_DIV = 0; flush = 0;
        data_operandA = '0; data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_result", data_result, 0);
        check("reset_exc",    data_exception, 0);
        check("reset_rdy",    data_resultRDY, 0);
        check("reset_busy",   busy, 0);
        reset = 1;

        op_lit("mul_7x-3",  1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 32);
        op_lit("mul_ovf",   1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1, 32);
        op_lit("mul_max",   1, 0, 32'h7FFF_FFFF,  32'd1,         32'h7FFF_FFFF, 0, 32);
        op_lit("div_-100",  0, 1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 0, 32);
        op_lit("div_zero",  0, 1, 32'd5,          32'd0,         32'h0,         1, 1);
        op_lit("div_ovf",   0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 32);
        op_lit("both",      1, 1, 32'd6,          32'd4,         32'd24,        0, 32);

        // Back-to-back: new MULT driven during the DONE cycle of the previous op.
        ctrl_MULT = 1; data_operandA = 32'hFFFF_FFF0; data_operandB = 32'hFFFF_FFF0;
        @(posedge clock); #1;
        ctrl_MULT = 0;
        wait_rdy(lat, seen);
        check("b2b_seen", seen, 1);
        check("b2b_lat", lat, 32);
        check("b2b_result", data_result, 32'd256);

        // Flush mid-multiply: no RDY, result keeps 256.
        @(posedge clock); #1;
        ctrl_MULT = 1; data_operandA = 32'd3; data_operandB = 32'd3;
        @(posedge clock); #1;
        ctrl_MULT = 0;
        repeat (9) @(posedge clock);
        #1 flush = 1;
        @(posedge clock); #1 flush = 0;
        @(negedge clock);
        check("flush_busy", busy, 0);
        rdy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_cnt++;
        end
        check("flush_no_rdy", rdy_cnt, 0);
        check("flush_result_kept", data_result, 32'd256);

        // Reset during a divide.
        @(posedge clock); #1;
        ctrl_DIV = 1; data_operandA = 32'd1000; data_operandB = 32'd3;
        @(posedge clock); #1;
        ctrl_DIV = 0;
        repeat (4) @(posedge clock);
        #1 reset = 0;
        #1;
        check("rst_mid_result", data_result, 0);
        check("rst_mid_exc",    data_exception, 0);
        check("rst_mid_busy",   busy, 0);
        check("rst_mid_rdy",    data_resultRDY, 0);
        @(posedge clock); #1 reset = 1;
        op_lit("restart", 0, 1, 32'd1000, 32'd3, 32'd333, 0, 32);

        // Randomised traffic checked every cycle by the compare process.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #1;
            ctrl_MULT     = ($urandom_range(0, 3) == 0);
            ctrl_DIV      = ($urandom_range(0, 3) == 0);
            flush         = ($urandom_range(0, 47) == 0);
            data_operandA = pick();
            data_operandB = pick();
        end
        @(posedge clock); #1;
        ctrl_MULT = 0; ctrl_DIV = 0; flush = 0;
        repeat (40) @(posedge clock);
        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
